pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_hazard_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller: destination scoreboard, forwarding selects,
// load-use stall/bubble and branch/jump flush. Optional counters: HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int AW         = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 3,
  parameter int SW         = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             id_valid_i,
  input  logic [AW-1:0]    id_rs_i,
  input  logic [AW-1:0]    id_rt_i,
  input  logic             id_use_rs_i,
  input  logic             id_use_rt_i,
  input  logic [AW-1:0]    id_rd_i,
  input  logic             id_regwrite_i,
  input  logic             id_memread_i,
  input  logic             id_jump_i,
  input  logic             ex_branch_taken_i,
  output logic             stall_o,
  output logic             bubble_o,
  output logic             flush_o,
  output logic [SW-1:0]    fwd_rs_o,
  output logic [SW-1:0]    fwd_rt_o,
  output logic [DEPTH-1:0] stage_valid_o,
  output logic [31:0]      stall_cnt_o,
  output logic [31:0]      flush_cnt_o
);

  // Index k-1 holds stage k (stage 1 = EX).
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] rw_q, rw_d;
  logic [DEPTH-1:0] mr_q, mr_d;
  logic [AW-1:0]    rd_q [DEPTH];
  logic [AW-1:0]    rd_d [DEPTH];

  logic [DEPTH-1:0] prod;
  int               rs_k, rt_k;
  logic             rs_mr, rt_mr;
  logic             load_use;

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      prod[k] = valid_q[k] & rw_q[k] & (rd_q[k] != '0);
    end
  end

  // Scan oldest to youngest so the youngest match overwrites.
  always_comb begin
    rs_k  = 0;
    rt_k  = 0;
    rs_mr = 1'b0;
    rt_mr = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (prod[k-1] && id_valid_i && id_use_rs_i && (id_rs_i != '0) && (rd_q[k-1] == id_rs_i)) begin
        rs_k  = k;
        rs_mr = mr_q[k-1];
      end
      if (prod[k-1] && id_valid_i && id_use_rt_i && (id_rt_i != '0) && (rd_q[k-1] == id_rt_i)) begin
        rt_k  = k;
        rt_mr = mr_q[k-1];
      end
    end
    load_use = ((rs_k != 0) && rs_mr && (rs_k + 1 < LOAD_STAGE)) ||
               ((rt_k != 0) && rt_mr && (rt_k + 1 < LOAD_STAGE));
  end

  always_comb begin
    stall_o  = 1'b0;
    bubble_o = 1'b0;
    flush_o  = 1'b0;
    fwd_rs_o = '0;
    fwd_rt_o = '0;
    if (rst_i) begin
      stall_o = 1'b0;
    end else if (!start_i) begin
      stall_o = 1'b1;
    end else begin
      fwd_rs_o = (rs_k < DEPTH) ? SW'(rs_k) : '0;
      fwd_rt_o = (rt_k < DEPTH) ? SW'(rt_k) : '0;
      if (ex_branch_taken_i) begin
        flush_o  = 1'b1;
        bubble_o = 1'b1;
      end else if (load_use) begin
        stall_o  = 1'b1;
        bubble_o = 1'b1;
      end else if (id_jump_i) begin
        flush_o = 1'b1;
      end
    end
  end

  assign stage_valid_o = rst_i ? '0 : valid_q;

  always_comb begin
    valid_d = valid_q;
    rw_d    = rw_q;
    mr_d    = mr_q;
    for (int k = 0; k < DEPTH; k++) begin
      rd_d[k] = rd_q[k];
    end
    if (start_i) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        valid_d[k] = valid_q[k-1];
        rw_d[k]    = rw_q[k-1];
        mr_d[k]    = mr_q[k-1];
        rd_d[k]    = rd_q[k-1];
      end
      valid_d[0] = id_valid_i & ~bubble_o;
      rw_d[0]    = id_regwrite_i;
      mr_d[0]    = id_memread_i;
      rd_d[0]    = id_rd_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      rw_q    <= '0;
      mr_q    <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        rd_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      rw_q    <= rw_d;
      mr_q    <= mr_d;
      for (int k = 0; k < DEPTH; k++) begin
        rd_q[k] <= rd_d[k];
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_o && start_i && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (flush_o && (flush_cnt_q != 32'hFFFF_FFFF))            flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = rst_i ? 32'd0 : stall_cnt_q;
  assign flush_cnt_o = rst_i ? 32'd0 : flush_cnt_q;
`else
  assign stall_cnt_o = 32'd0;
  assign flush_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: default instance plus DEPTH=5/LOAD_STAGE=4 instance.
module tb_pipe_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i, start_i, id_valid_i, id_use_rs_i, id_use_rt_i;
  logic [4:0]  id_rs_i, id_rt_i, id_rd_i;
  logic        id_regwrite_i, id_memread_i, id_jump_i, ex_branch_taken_i;

  logic        stall_o, bubble_o, flush_o;
  logic [2:0]  fwd_rs_o, fwd_rt_o, stage_valid_o;
  logic [31:0] stall_cnt_o, flush_cnt_o;

  logic        stall5, bubble5, flush5;
  logic [2:0]  fwd_rs5, fwd_rt5;
  logic [4:0]  stage_valid5;
  logic [31:0] stall_cnt5, flush_cnt5;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  pipe_hazard_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .id_valid_i(id_valid_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_use_rs_i(id_use_rs_i), .id_use_rt_i(id_use_rt_i),
    .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
    .id_jump_i(id_jump_i), .ex_branch_taken_i(ex_branch_taken_i),
    .stall_o(stall_o), .bubble_o(bubble_o), .flush_o(flush_o),
    .fwd_rs_o(fwd_rs_o), .fwd_rt_o(fwd_rt_o), .stage_valid_o(stage_valid_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  pipe_hazard_ctrl #(.AW(5), .DEPTH(5), .LOAD_STAGE(4), .SW(3)) dut5 (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .id_valid_i(id_valid_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_use_rs_i(id_use_rs_i), .id_use_rt_i(id_use_rt_i),
    .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
    .id_jump_i(id_jump_i), .ex_branch_taken_i(ex_branch_taken_i),
    .stall_o(stall5), .bubble_o(bubble5), .flush_o(flush5),
    .fwd_rs_o(fwd_rs5), .fwd_rt_o(fwd_rt5), .stage_valid_o(stage_valid5),
    .stall_cnt_o(stall_cnt5), .flush_cnt_o(flush_cnt5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic id_set(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic jmp, input logic br);
    id_valid_i = v;  id_rs_i = rs;  id_rt_i = rt;  id_use_rs_i = urs;  id_use_rt_i = urt;
    id_rd_i = rd;  id_regwrite_i = rw;  id_memread_i = mr;  id_jump_i = jmp;
    ex_branch_taken_i = br;
    #1;
  endtask

  task automatic idle();
    id_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    idle();
    repeat (3) tick();
  endtask

  initial begin
    rst_i = 1'b1;
    start_i = 1'b0;
    idle();
    repeat (3) tick();
    chk("rst_stall", stall_o, 0);
    chk("rst_bubble", bubble_o, 0);
    chk("rst_fwd", {fwd_rs_o, fwd_rt_o}, 0);

    rst_i = 1'b0;
    start_i = 1'b1;
    #1;
    chk("idle_outs", {stall_o, bubble_o, flush_o, fwd_rs_o, fwd_rt_o}, 0);
    chk("idle_valid", stage_valid_o, 0);
    chk("idle_cnts", stall_cnt_o | flush_cnt_o, 0);
    tick();

    // add $3 ; add $4,$3,$1
    id_set(1, 1, 2, 1, 1, 3, 1, 0, 0, 0);
    chk("a_nostall0", stall_o, 0);
    tick();
    id_set(1, 3, 1, 1, 1, 4, 1, 0, 0, 0);
    chk("a_fwd_rs", fwd_rs_o, 1);
    chk("a_fwd_rt", fwd_rt_o, 0);
    chk("a_stall", stall_o, 0);
    chk("a_valid", stage_valid_o, 3'b001);
    tick();
    drain();
    chk("a_drained", stage_valid_o, 0);

    // one NOP between (NOP written as a $0 write)
    id_set(1, 1, 2, 1, 1, 3, 1, 0, 0, 0);
    tick();
    id_set(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tick();
    id_set(1, 3, 1, 1, 1, 4, 1, 0, 0, 0);
    chk("b_fwd_rs", fwd_rs_o, 2);
    chk("b_valid", stage_valid_o, 3'b011);
    tick();
    drain();

    // two NOPs between: producer has reached WB
    id_set(1, 1, 2, 1, 1, 3, 1, 0, 0, 0);
    tick();
    id_set(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tick();
    id_set(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tick();
    id_set(1, 3, 1, 1, 1, 4, 1, 0, 0, 0);
    chk("c_fwd_rs", fwd_rs_o, 0);
    chk("c_stall", stall_o, 0);
    chk("c_valid", stage_valid_o, 3'b111);
    tick();
    drain();

    // load to $0 then read $0
    id_set(1, 1, 0, 1, 0, 0, 1, 1, 0, 0);
    tick();
    id_set(1, 0, 0, 1, 1, 6, 1, 0, 0, 0);
    chk("z_stall", stall_o, 0);
    chk("z_fwd", {fwd_rs_o, fwd_rt_o}, 0);
    tick();
    drain();

    // lw $2 ; sub $5,$2,$2
    id_set(1, 1, 0, 1, 0, 2, 1, 1, 0, 0);
    tick();
    id_set(1, 2, 2, 1, 1, 5, 1, 0, 0, 0);
    chk("d_stall1", stall_o, 1);
    chk("d_bubble1", bubble_o, 1);
    chk("d_flush1", flush_o, 0);
    tick();
    chk("d_stall2", stall_o, 0);
    chk("d_bubble2", bubble_o, 0);
    chk("d_fwd_rs", fwd_rs_o, 2);
    chk("d_fwd_rt", fwd_rt_o, 2);
    chk("d_valid", stage_valid_o, 3'b010);
    chk("d_stall_cnt", stall_cnt_o, PERF ? 1 : 0);
    tick();
    drain();

    // taken branch on top of a load-use
    id_set(1, 1, 0, 1, 0, 2, 1, 1, 0, 0);
    tick();
    id_set(1, 2, 2, 1, 1, 5, 1, 0, 0, 1);
    chk("e_flush", flush_o, 1);
    chk("e_bubble", bubble_o, 1);
    chk("e_stall", stall_o, 0);
    tick();
    idle();
    chk("e_valid", stage_valid_o, 3'b010);
    chk("e_flush_cnt", flush_cnt_o, PERF ? 1 : 0);
    tick();

    // plain jump
    id_set(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("j_flush", flush_o, 1);
    chk("j_stall", {stall_o, bubble_o}, 0);
    tick();

    // jr $2 right behind lw $2: stall wins, then jump flushes
    id_set(1, 1, 0, 1, 0, 2, 1, 1, 0, 0);
    tick();
    id_set(1, 2, 0, 1, 0, 0, 0, 0, 1, 0);
    chk("js_stall", stall_o, 1);
    chk("js_flush", flush_o, 0);
    chk("js_bubble", bubble_o, 1);
    tick();
    chk("js_flush2", flush_o, 1);
    chk("js_stall2", stall_o, 0);
    chk("js_stall_cnt", stall_cnt_o, PERF ? 2 : 0);
    tick();
    chk("js_flush_cnt", flush_cnt_o, PERF ? 3 : 0);
    drain();

    // start_i low for two cycles mid-sequence
    id_set(1, 1, 2, 1, 1, 3, 1, 0, 0, 0);
    tick();
    id_set(1, 1, 2, 1, 1, 7, 1, 0, 0, 0);
    tick();
    start_i = 1'b0;
    id_set(1, 7, 3, 1, 1, 8, 1, 0, 0, 0);
    chk("f_stall", stall_o, 1);
    chk("f_others", {bubble_o, flush_o, fwd_rs_o, fwd_rt_o}, 0);
    chk("f_valid0", stage_valid_o, 3'b011);
    tick();
    tick();
    chk("f_valid_frozen", stage_valid_o, 3'b011);
    chk("f_stall_cnt", stall_cnt_o, PERF ? 2 : 0);
    start_i = 1'b1;
    #1;
    chk("f_fwd_rs", fwd_rs_o, 1);
    chk("f_fwd_rt", fwd_rt_o, 2);
    chk("f_resume_stall", stall_o, 0);
    tick();
    chk("f_shift", stage_valid_o, 3'b111);
    drain();

    // reset in the middle of a load-use stall
    id_set(1, 1, 0, 1, 0, 2, 1, 1, 0, 0);
    tick();
    id_set(1, 2, 2, 1, 1, 5, 1, 0, 0, 0);
    chk("r_pre_stall", stall_o, 1);
    rst_i = 1'b1;
    #1;
    chk("r_outs", {stall_o, bubble_o, flush_o, fwd_rs_o, fwd_rt_o}, 0);
    tick();
    rst_i = 1'b0;
    idle();
    chk("r_valid", stage_valid_o, 0);
    chk("r_cnts", stall_cnt_o | flush_cnt_o, 0);
    chk("r_stall_after", stall_o, 0);
    tick();

    // DEPTH=5, LOAD_STAGE=4: two stall cycles then forward from stage 3
    id_set(1, 1, 0, 1, 0, 2, 1, 1, 0, 0);
    tick();
    id_set(1, 2, 0, 1, 0, 5, 1, 0, 0, 0);
    chk("p_stall1", stall5, 1);
    tick();
    chk("p_stall2", stall5, 1);
    chk("p_bubble2", bubble5, 1);
    tick();
    chk("p_stall3", stall5, 0);
    chk("p_fwd_rs", fwd_rs5, 3);
    chk("p_valid", stage_valid5, 5'b00100);
    chk("p_stall_cnt", stall_cnt5, PERF ? 2 : 0);
    tick();
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
